// File: rtl/oam_fp_pkg.sv
// Shared constants for the approximate-multiplier result packing stage.
package oam_fp_pkg;

    localparam int DEF_MANTISSA_WIDTH = 15;
    localparam int DEF_EXP_WIDTH      = 8;
    localparam int DEF_BIAS           = 127;

    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UDF  = 1;
    localparam int FLAG_ZERO = 0;

    // SHIFT_GE2 is really 2'b1x: only bit 1 is examined for that case.
    localparam logic [1:0] SHIFT_GE2 = 2'b10;
    localparam logic [1:0] SHIFT_GE1 = 2'b01;
    localparam logic [1:0] SHIFT_LT1 = 2'b00;

    function automatic logic signed [2:0] shift_adj(input logic [1:0] shift);
        if (shift[1])
            return 3'sd1;
        else if (shift == SHIFT_GE1)
            return 3'sd0;
        else
            return -3'sd1;
    endfunction

endpackage

// File: rtl/oam_exp_adjust.sv
// Combinational exponent adjust with zero / saturate / flush-to-zero selection.
module oam_exp_adjust
    import oam_fp_pkg::*;
#(
    parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH,
    parameter int EXP_WIDTH      = DEF_EXP_WIDTH
) (
    input  logic signed [EXP_WIDTH+1:0]  esum,
    input  logic        [1:0]            shift,
    input  logic                         zero,
    input  logic        [MANTISSA_WIDTH-1:0] mant_in,
    output logic        [EXP_WIDTH-1:0]  res_exp,
    output logic        [MANTISSA_WIDTH-1:0] res_mant,
    output logic        [2:0]            res_flags
);

    logic signed [2:0]           adj;
    logic signed [EXP_WIDTH+1:0] e;
    logic                        e_ovf;
    logic                        e_udf;

    assign adj   = shift_adj(shift);
    assign e     = esum + {{(EXP_WIDTH-1){adj[2]}}, adj};
    assign e_ovf = (e >= $signed({2'b00, {EXP_WIDTH{1'b1}}}));
    assign e_udf = e[EXP_WIDTH+1] || (e == '0);

    always_comb begin
        res_exp   = '0;
        res_mant  = '0;
        res_flags = '0;
        if (zero) begin
            res_flags[FLAG_ZERO] = 1'b1;
        end else if (e_ovf) begin
            res_exp             = {{(EXP_WIDTH-1){1'b1}}, 1'b0};
            res_mant            = '1;
            res_flags[FLAG_OVF] = 1'b1;
        end else if (e_udf) begin
            res_flags[FLAG_UDF] = 1'b1;
        end else begin
            res_exp  = e[EXP_WIDTH-1:0];
            res_mant = mant_in;
        end
    end

endmodule

// File: rtl/oam_fp_pack_stage.sv
// Two-stage valid/ready packer: exponent sum/sign in stage 1, adjust and pack in stage 2.
// Optional OAM_PACK_STATS_EN adds saturating overflow/underflow/beat counters.
module oam_fp_pack_stage
    import oam_fp_pkg::*;
#(
    parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH,
    parameter int EXP_WIDTH      = DEF_EXP_WIDTH,
    parameter int BIAS           = DEF_BIAS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      sign_x,
    input  logic                      sign_y,
    input  logic [EXP_WIDTH-1:0]      exp_x,
    input  logic [EXP_WIDTH-1:0]      exp_y,
    input  logic [MANTISSA_WIDTH-1:0] mant_in,
    input  logic [1:0]                shift_in,
    input  logic                      zero_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sign,
    output logic [EXP_WIDTH-1:0]      out_exp,
    output logic [MANTISSA_WIDTH-1:0] out_mant,
    output logic [2:0]                out_flags
`ifdef OAM_PACK_STATS_EN
    ,
    output logic [15:0]               stat_ovf_cnt,
    output logic [15:0]               stat_udf_cnt,
    output logic [15:0]               stat_beats_cnt
`endif
);

    localparam logic signed [EXP_WIDTH+1:0] BIAS_S = BIAS[EXP_WIDTH+1:0];

    logic                        s1_valid;
    logic                        s1_sign;
    logic signed [EXP_WIDTH+1:0] s1_esum;
    logic                        s1_zero;
    logic [MANTISSA_WIDTH-1:0]   s1_mant;
    logic [1:0]                  s1_shift;

    logic                        s2_can_load;
    logic                        in_fire;
    logic signed [EXP_WIDTH+1:0] esum_next;
    logic [EXP_WIDTH-1:0]        adj_exp;
    logic [MANTISSA_WIDTH-1:0]   adj_mant;
    logic [2:0]                  adj_flags;

    assign s2_can_load = !out_valid || out_ready;
    assign in_ready    = !s1_valid || s2_can_load;
    assign in_fire     = in_valid && in_ready;
    assign esum_next   = $signed({2'b00, exp_x}) + $signed({2'b00, exp_y}) - BIAS_S;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_esum  <= '0;
            s1_zero  <= 1'b0;
            s1_mant  <= '0;
            s1_shift <= '0;
        end else begin
            // When in_ready is high, stage 1 is either empty or moving into stage 2.
            if (in_ready)
                s1_valid <= in_valid;
            if (in_fire) begin
                s1_sign  <= sign_x ^ sign_y;
                s1_esum  <= esum_next;
                s1_zero  <= zero_in || (exp_x == '0) || (exp_y == '0);
                s1_mant  <= mant_in;
                s1_shift <= shift_in;
            end
        end
    end

    oam_exp_adjust #(
        .MANTISSA_WIDTH (MANTISSA_WIDTH),
        .EXP_WIDTH      (EXP_WIDTH)
    ) u_exp_adjust (
        .esum      (s1_esum),
        .shift     (s1_shift),
        .zero      (s1_zero),
        .mant_in   (s1_mant),
        .res_exp   (adj_exp),
        .res_mant  (adj_mant),
        .res_flags (adj_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_flags <= '0;
        end else if (s2_can_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign  <= s1_sign;
                out_exp   <= adj_exp;
                out_mant  <= adj_mant;
                out_flags <= adj_flags;
            end
        end
    end

`ifdef OAM_PACK_STATS_EN
    logic out_fire;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ovf_cnt   <= '0;
            stat_udf_cnt   <= '0;
            stat_beats_cnt <= '0;
        end else if (out_fire) begin
            if (out_flags[FLAG_OVF] && stat_ovf_cnt != 16'hFFFF)
                stat_ovf_cnt <= stat_ovf_cnt + 16'd1;
            if (out_flags[FLAG_UDF] && stat_udf_cnt != 16'hFFFF)
                stat_udf_cnt <= stat_udf_cnt + 16'd1;
            if (stat_beats_cnt != 16'hFFFF)
                stat_beats_cnt <= stat_beats_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_oam_fp_pack_stage.sv
// Directed bench for oam_fp_pack_stage: packing cases, boundaries, backpressure and mid-run reset.
module tb_oam_fp_pack_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_x = 1'b0;
    logic        sign_y = 1'b0;
    logic [7:0]  exp_x = '0;
    logic [7:0]  exp_y = '0;
    logic [14:0] mant_in = '0;
    logic [1:0]  shift_in = '0;
    logic        zero_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [14:0] out_mant;
    logic [2:0]  out_flags;
`ifdef OAM_PACK_STATS_EN
    logic [15:0] stat_ovf_cnt;
    logic [15:0] stat_udf_cnt;
    logic [15:0] stat_beats_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    oam_fp_pack_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_x    (sign_x),
        .sign_y    (sign_y),
        .exp_x     (exp_x),
        .exp_y     (exp_y),
        .mant_in   (mant_in),
        .shift_in  (shift_in),
        .zero_in   (zero_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_flags (out_flags)
`ifdef OAM_PACK_STATS_EN
        ,
        .stat_ovf_cnt   (stat_ovf_cnt),
        .stat_udf_cnt   (stat_udf_cnt),
        .stat_beats_cnt (stat_beats_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_beat(input string tag,
                            input logic sx, input logic sy,
                            input logic [7:0] ex, input logic [7:0] ey,
                            input logic [14:0] m, input logic [1:0] sh, input logic z,
                            input logic e_sign, input logic [7:0] e_exp,
                            input logic [14:0] e_mant, input logic [2:0] e_flags);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sign_x    = sx;
        sign_y    = sy;
        exp_x     = ex;
        exp_y     = ey;
        mant_in   = m;
        shift_in  = sh;
        zero_in   = z;
        step();
        in_valid = 1'b0;
        zero_in  = 1'b0;
        step();
        check_val({tag, "_valid"}, out_valid, 1);
        check_val({tag, "_sign"},  out_sign,  e_sign);
        check_val({tag, "_exp"},   out_exp,   e_exp);
        check_val({tag, "_mant"},  out_mant,  e_mant);
        check_val({tag, "_flags"}, out_flags, e_flags);
        step();
    endtask

    initial begin
        int sent;
        int rcvd;
        int done_k;
        logic stalled_prev;
        logic [14:0] prev_mant;

        step();
        step();
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_sign",  out_sign,  0);
        check_val("rst_out_exp",   out_exp,   0);
        check_val("rst_out_mant",  out_mant,  0);
        check_val("rst_out_flags", out_flags, 0);
        rst = 1'b0;
        #1;
        check_val("rst_in_ready", in_ready, 1);

        //          tag      sx    sy    ex    ey    mant      sh     z     sign  exp    mant      flags
        run_beat("unity",  1'b0, 1'b0, 8'd127, 8'd127, 15'h1234, 2'b01, 1'b0, 1'b0, 8'd127, 15'h1234, 3'b000);
        run_beat("shl",    1'b1, 1'b0, 8'd128, 8'd127, 15'h0555, 2'b10, 1'b0, 1'b1, 8'd129, 15'h0555, 3'b000);
        run_beat("sat",    1'b0, 1'b1, 8'd254, 8'd254, 15'h0001, 2'b01, 1'b0, 1'b1, 8'd254, 15'h7FFF, 3'b100);
        run_beat("flush",  1'b1, 1'b1, 8'd1,   8'd1,   15'h2222, 2'b00, 1'b0, 1'b0, 8'd0,   15'h0000, 3'b010);
        run_beat("zin",    1'b1, 1'b0, 8'd200, 8'd50,  15'h3333, 2'b01, 1'b1, 1'b1, 8'd0,   15'h0000, 3'b001);
        run_beat("zexp",   1'b0, 1'b1, 8'd0,   8'd200, 15'h4444, 2'b10, 1'b0, 1'b1, 8'd0,   15'h0000, 3'b001);
        run_beat("e255",   1'b0, 1'b0, 8'd200, 8'd182, 15'h0F0F, 2'b01, 1'b0, 1'b0, 8'd254, 15'h7FFF, 3'b100);
        run_beat("e254",   1'b0, 1'b0, 8'd200, 8'd181, 15'h0F0F, 2'b01, 1'b0, 1'b0, 8'd254, 15'h0F0F, 3'b000);
        run_beat("e0",     1'b0, 1'b0, 8'd64,  8'd64,  15'h1111, 2'b00, 1'b0, 1'b0, 8'd0,   15'h0000, 3'b010);
        run_beat("e1",     1'b0, 1'b0, 8'd64,  8'd64,  15'h1111, 2'b01, 1'b0, 1'b0, 8'd1,   15'h1111, 3'b000);
        run_beat("sh11",   1'b1, 1'b1, 8'd100, 8'd100, 15'h5A5A, 2'b11, 1'b0, 1'b0, 8'd74,  15'h5A5A, 3'b000);

        // Five-beat stream with out_ready low for cycles 2..6.
        sent = 0;
        rcvd = 0;
        done_k = -1;
        stalled_prev = 1'b0;
        prev_mant = '0;
        sign_x = 1'b0;
        sign_y = 1'b0;
        exp_x = 8'd127;
        exp_y = 8'd127;
        shift_in = 2'b01;
        zero_in = 1'b0;
        for (int k = 0; k < 40 && rcvd < 5; k++) begin
            out_ready = !(k >= 2 && k <= 6);
            in_valid  = (sent < 5);
            mant_in   = 15'(32'h0100 + sent);
            #1;
            if (k == 4)
                check_val("bp_in_ready_low", in_ready, 0);
            if (stalled_prev)
                check_val("bp_hold_mant", out_mant, prev_mant);
            if (out_valid && out_ready) begin
                check_val("bp_order", out_mant, 32'h0100 + rcvd);
                check_val("bp_exp", out_exp, 127);
                rcvd++;
                if (rcvd == 5)
                    done_k = k;
            end
            if (in_valid && in_ready)
                sent++;
            stalled_prev = out_valid && !out_ready;
            prev_mant    = out_mant;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("bp_rcvd", rcvd, 5);
        check_val("bp_done_cycle", done_k, 11);
        step();
        check_val("bp_no_dup", out_valid, 0);

        // Mid-run reset with two beats held in the pipe.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mant_in   = 15'h0AAA;
        step();
        mant_in   = 15'h0BBB;
        step();
        in_valid = 1'b0;
        check_val("pre_rst_full", in_ready, 0);
        rst = 1'b1;
        step();
        check_val("rst_mid_valid", out_valid, 0);
        rst = 1'b0;
        step();
        check_val("rst_after_valid", out_valid, 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mant_in   = 15'h0CCC;
        step();
        in_valid = 1'b0;
        check_val("rst_c_lat1", out_valid, 0);
        step();
        check_val("rst_c_valid", out_valid, 1);
        check_val("rst_c_mant", out_mant, 15'h0CCC);
        step();
        check_val("rst_no_stale", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/oam_fp_pack_stage.md
Name: oam_fp_pack_stage

Overview:
- Pipelined result-packing stage directly downstream of the approximate mantissa multiplier.
- Consumes the normalized mantissa and the 2-bit overflow/shift code from that multiplier, plus the operand signs and exponents.
- Produces a packed floating-point product: sign, adjusted exponent and mantissa, with saturation and flush-to-zero.
- Two-stage valid/ready pipeline placed between the mantissa core and the result writeback.

Parameters:
- MANTISSA_WIDTH, 15, stored fraction bits (hidden bit excluded).
- EXP_WIDTH, 8, biased exponent width.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- sign_x, sign_y  in  1 each  operand signs
- exp_x, exp_y  in  EXP_WIDTH each  biased operand exponents
- mant_in  in  MANTISSA_WIDTH  normalized mantissa from the multiplier
- shift_in  in  2  multiplier shift code
- zero_in  in  1  either operand is zero
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_sign  out  1  product sign
- out_exp  out  EXP_WIDTH  product biased exponent
- out_mant  out  MANTISSA_WIDTH  product fraction
- out_flags  out  3  {overflow, underflow, zero}

Behaviour:
- Reset: out_valid=0, out_sign=0, out_exp=0, out_mant=0, out_flags=0, both stage valids=0. in_ready=1 in the cycle after reset deasserts.
- Handshake:
  - Input beat transfers when in_valid && in_ready. Output beat transfers when out_valid && out_ready.
  - Output data must hold stable while out_valid && !out_ready.
  - in_ready = !s1_valid || s2_can_load, where s2_can_load = !out_valid || out_ready.
  - in_ready is combinational from out_ready; there is no path from in_valid to in_ready.
- Latency and throughput: 2 cycles in to out_valid; 1 beat/cycle when unstalled. Full stall holds 2 beats and loses none.
- Stage 1 (registers on accept):
  - sign = sign_x ^ sign_y.
  - esum = exp_x + exp_y - BIAS, signed, EXP_WIDTH+2 bits.
  - zero = zero_in || exp_x==0 || exp_y==0.
  - mant_in and shift_in are registered unchanged.
- Stage 2 (registers when s2_can_load):
  - adj = +1 if shift[1]; 0 if shift==2'b01; -1 if shift==2'b00.
  - e = esum + adj.
  - Priority order:
    - zero: exp=0, mant=0, flags=3'b001.
    - else e >= 2^EXP_WIDTH-1: exp=2^EXP_WIDTH-2, mant=all ones, flags=3'b100.
    - else e <= 0: exp=0, mant=0, flags=3'b010.
    - else: exp=e[EXP_WIDTH-1:0], mant=mant_in, flags=0.
  - out_sign = registered sign in every case, including zero.
- Bubbles: an empty stage 1 moving into stage 2 clears out_valid. Data registers need not clear on a bubble.
- Reset mid-operation: all in-flight beats are dropped; no output beat in the reset cycle or the cycle after.
- Simultaneous accept and drain with the pipe full: both occur in the same cycle, with no bubble and no duplication.

Optional Feature:
- Macro: OAM_PACK_STATS_EN.
- Defined:
  - Extra outputs stat_ovf_cnt, stat_udf_cnt, stat_beats_cnt, each 16 bits.
  - Each increments on an output transfer with the matching condition (any transfer for stat_beats_cnt).
  - Counters saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and counters do not exist; datapath behaviour is identical.

Decomposition:
- Package oam_fp_pkg:
  - Flag bit index constants FLAG_OVF=2, FLAG_UDF=1, FLAG_ZERO=0.
  - Shift code constants SHIFT_GE2=2'b1x, SHIFT_GE1=2'b01, SHIFT_LT1=2'b00.
  - Default EXP_WIDTH and BIAS.
- Sub-module oam_exp_adjust:
  - Combinational stage-2 logic: esum, shift, zero in → exp, mant, flags out.
  - Verified standalone.

Test Plan:
- exp_x=127, exp_y=127, shift=01, mant=15'h1234, out_ready=1 → after 2 cycles: out_exp=127, out_mant=15'h1234, flags=0.
- exp_x=128, exp_y=127, shift=10, sign_x=1, sign_y=0 → out_exp=129, out_sign=1.
- exp_x=254, exp_y=254, shift=01 → out_exp=254, out_mant=15'h7FFF, flags=3'b100.
- Flush cases:
  - exp_x=1, exp_y=1, shift=00 → out_exp=0, out_mant=0, flags=3'b010.
  - zero_in=1 with any exponents → flags=3'b001, out_sign=sign_x^sign_y.
- Backpressure:
  - Stream 5 beats with in_valid held high; hold out_ready=0 for cycles 2-6.
  - in_ready drops once 2 beats are held; all 5 emerge in order, none duplicated.
  - out_data stays stable while stalled.
- Reset with 2 beats in flight: assert rst for 1 cycle → out_valid=0 and no stale beat; the next accepted beat appears exactly 2 cycles later.
